// File: rtl/vbfs_scatter_fifo.sv
// rtl/vbfs_scatter_fifo.sv - BFS scatter FWFT buffer with zero-neighbour drop and per-round message count
module vbfs_scatter_fifo #(
  parameter int ID_WIDTH    = 32,
  parameter int ROUND_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [ID_WIDTH-1:0]      num_neighbors_in,
  input  logic [ID_WIDTH-1:0]      neighbor_in,
  input  logic [ID_WIDTH-1:0]      sender_in,
  input  logic [ROUND_WIDTH-1:0]   round_in,
  input  logic                     barrier_in,
  input  logic                     valid_in,
  output logic                     ready,
  output logic [ID_WIDTH-1:0]      neighbor_out,
  output logic [ID_WIDTH-1:0]      sender_out,
  output logic [ROUND_WIDTH-1:0]   round_out,
  output logic                     barrier_out,
  output logic                     valid_out,
  input  logic                     message_ack,
  output logic [COUNT_WIDTH-1:0]   msg_count_out,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * ID_WIDTH + ROUND_WIDTH + 1;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [EW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            occ;
  logic [COUNT_WIDTH-1:0] count;
  logic [EW-1:0]          head;
  logic                   accept;
  logic                   wr_en;
  logic                   pop;

  // ready and valid_out come only from registered occupancy, so neither
  // depends combinationally on the other side's handshake.
  assign ready     = (occ != FULL_LEVEL);
  assign valid_out = (occ != '0);
  assign accept    = valid_in & ready;
  assign wr_en     = accept & (barrier_in | (num_neighbors_in != '0));
  assign pop       = valid_out & message_ack;

  assign head = mem[rd_ptr];
  assign {neighbor_out, sender_out, round_out, barrier_out} = head;

  assign msg_count_out = count;
  assign level         = occ;

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {neighbor_in, sender_in, round_in, barrier_in};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   occ <= occ + (AW + 1)'(1);
        2'b01:   occ <= occ - (AW + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // A barrier pop closes the round; the count seen with the barrier at the
  // head is therefore that round's total.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count <= '0;
    end else if (pop) begin
      if (head[0]) begin
        count <= '0;
      end else if (count != '1) begin
        count <= count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vbfs_scatter_fifo.sv
// tb/tb_vbfs_scatter_fifo.sv - scoreboard bench for vbfs_scatter_fifo
module tb_vbfs_scatter_fifo;

  localparam int ID_WIDTH    = 32;
  localparam int ROUND_WIDTH = 2;
  localparam int DEPTH       = 8;
  localparam int COUNT_WIDTH = 16;
  localparam int LW          = $clog2(DEPTH) + 1;

  typedef struct {
    logic [ID_WIDTH-1:0]    nb;
    logic [ID_WIDTH-1:0]    snd;
    logic [ROUND_WIDTH-1:0] rnd;
    logic                   bar;
  } ent_t;

  logic                   sys_clk = 1'b0;
  logic                   sys_rst;
  logic [ID_WIDTH-1:0]    num_neighbors_in;
  logic [ID_WIDTH-1:0]    neighbor_in;
  logic [ID_WIDTH-1:0]    sender_in;
  logic [ROUND_WIDTH-1:0] round_in;
  logic                   barrier_in;
  logic                   valid_in;
  logic                   ready;
  logic [ID_WIDTH-1:0]    neighbor_out;
  logic [ID_WIDTH-1:0]    sender_out;
  logic [ROUND_WIDTH-1:0] round_out;
  logic                   barrier_out;
  logic                   valid_out;
  logic                   message_ack;
  logic [COUNT_WIDTH-1:0] msg_count_out;
  logic [LW-1:0]          level;

  ent_t exp_q[$];
  int   exp_cnt;
  int   n_cmp;
  int   n_fail;

  vbfs_scatter_fifo #(
    .ID_WIDTH(ID_WIDTH), .ROUND_WIDTH(ROUND_WIDTH),
    .DEPTH(DEPTH), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .num_neighbors_in(num_neighbors_in), .neighbor_in(neighbor_in),
    .sender_in(sender_in), .round_in(round_in), .barrier_in(barrier_in),
    .valid_in(valid_in), .ready(ready),
    .neighbor_out(neighbor_out), .sender_out(sender_out),
    .round_out(round_out), .barrier_out(barrier_out), .valid_out(valid_out),
    .message_ack(message_ack), .msg_count_out(msg_count_out), .level(level)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs and outputs are stable at negedge, so everything the
  // next rising edge will do is decided here.
  initial begin
    ent_t h;
    bit   full;
    exp_cnt = 0;
    @(posedge sys_clk);
    forever begin
      @(negedge sys_clk);
      check("level", 64'(level), 64'(exp_q.size()));
      check("valid_out", 64'(valid_out), 64'(exp_q.size() != 0));
      check("ready", 64'(ready), 64'(exp_q.size() < DEPTH));
      check("msg_count", 64'(msg_count_out), 64'(exp_cnt));
      if (sys_rst) begin
        exp_q.delete();
        exp_cnt = 0;
      end else begin
        full = (exp_q.size() == DEPTH);
        if (message_ack && exp_q.size() != 0) begin
          h = exp_q.pop_front();
          check("neighbor_out", 64'(neighbor_out), 64'(h.nb));
          check("sender_out", 64'(sender_out), 64'(h.snd));
          check("round_out", 64'(round_out), 64'(h.rnd));
          check("barrier_out", 64'(barrier_out), 64'(h.bar));
          if (h.bar) exp_cnt = 0;
          else if (exp_cnt < (1 << COUNT_WIDTH) - 1) exp_cnt++;
        end
        if (valid_in && !full && (barrier_in || num_neighbors_in != 0)) begin
          h.nb  = neighbor_in;
          h.snd = sender_in;
          h.rnd = round_in;
          h.bar = barrier_in;
          exp_q.push_back(h);
        end
      end
    end
  end

  task automatic send_beat(input int nn, input int nb, input int snd, input int rnd, input bit bar);
    bit acc;
    int t;
    num_neighbors_in = ID_WIDTH'(nn);
    neighbor_in      = ID_WIDTH'(nb);
    sender_in        = ID_WIDTH'(snd);
    round_in         = ROUND_WIDTH'(rnd);
    barrier_in       = bar;
    valid_in         = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      @(negedge sys_clk);
      acc = ready;
      @(posedge sys_clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got ready=0 expected accept within 100 cycles");
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int t;
    valid_in    = 1'b0;
    message_ack = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * DEPTH + 10) begin
      @(posedge sys_clk);
      #1;
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
    end
    message_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    sys_rst = 1'b1;
    valid_in = 1'b0;
    message_ack = 1'b0;
    num_neighbors_in = '0;
    neighbor_in = '0;
    sender_in = '0;
    round_in = '0;
    barrier_in = 1'b0;
    repeat (2) step();
    sys_rst = 1'b0;
    step();

    // in-order delivery with continuous ack
    message_ack = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(2, 5 + i, 1, 1, 1'b0);
    drain();

    // fill to DEPTH, ninth beat held off until one ack
    for (int i = 0; i < DEPTH; i++) send_beat(2, 10 + i, 2, 2, 1'b0);
    num_neighbors_in = 2;
    neighbor_in = 99;
    valid_in = 1'b1;
    repeat (3) step();
    message_ack = 1'b1;
    step();
    message_ack = 1'b0;
    send_beat(2, 99, 2, 2, 1'b0);
    drain();

    // zero-neighbour update is dropped
    message_ack = 1'b1;
    send_beat(0, 8, 3, 0, 1'b0);
    send_beat(2, 9, 3, 0, 1'b0);
    drain();

    // barrier closes a round of four messages
    for (int i = 0; i < 4; i++) send_beat(1, 20 + i, 4, 1, 1'b0);
    send_beat(0, 0, 0, 1, 1'b1);
    for (int i = 0; i < 2; i++) send_beat(3, 30 + i, 4, 2, 1'b0);
    drain();

    // randomized traffic
    for (int i = 0; i < 1000; i++) begin
      valid_in         = 1'($urandom % 2);
      message_ack      = 1'($urandom % 2);
      num_neighbors_in = ID_WIDTH'($urandom_range(0, 3));
      neighbor_in      = $urandom;
      sender_in        = $urandom;
      round_in         = ROUND_WIDTH'($urandom);
      barrier_in       = ($urandom % 8) == 0;
      step();
    end
    drain();

    // reset mid-transfer discards buffered entries
    for (int i = 0; i < 5; i++) send_beat(1, 40 + i, 5, 3, 1'b0);
    sys_rst = 1'b1;
    valid_in = 1'b1;
    step();
    sys_rst = 1'b0;
    valid_in = 1'b0;
    step();
    send_beat(2, 77, 6, 0, 1'b0);
    drain();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
